apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_cmd_master_if.sv | 42 ++++
 rtl/apb_cmd_master.sv | 125 ++++++++++++
 tb/tb_apb_cmd_master.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_master_if.sv
// Command/response handshake and APB bus bundle for apb_cmd_master.
// The master modport is the DUT's view; slave is the environment's view.
interface apb_cmd_master_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;

   logic [ADDR_W-1:0] paddr;
   logic              pwrite;
   logic [DATA_W-1:0] pwdata;
   logic              psel;
   logic              penable;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output paddr, pwrite, pwdata, psel, penable,
      input  prdata, pready, pslverr
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  paddr, pwrite, pwdata, psel, penable,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-command APB master: accepts one command in IDLE, runs SETUP/ACCESS,
// and reports completion, slave error or wait-state timeout with a one-cycle pulse.
module apb_cmd_master #(
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             pclk,
   input  logic             rstn,
   apb_cmd_master_if.master bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam int               CNT_W    = 8;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic              pwrite_q, pwrite_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic              ready_en_q, ready_en_d;

   // ready_en_q keeps cmd_ready low until the first clock after reset release.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      paddr_d       = paddr_q;
      pwrite_d      = pwrite_q;
      pwdata_d      = pwdata_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      ready_en_d    = 1'b1;

      case (state_q)
         IDLE: begin
            if (bus.cmd_valid && ready_en_q) begin
               paddr_d    = bus.cmd_addr;
               pwrite_d   = bus.cmd_write;
               pwdata_d   = bus.cmd_wdata;
               wait_cnt_d = '0;
               state_d    = SETUP;
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            // pready wins over a timeout landing in the same cycle
            if (bus.pready) begin
               rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
               rsp_err_d     = bus.pslverr;
               rsp_timeout_d = 1'b0;
               state_d       = RESP;
            end else if (wait_cnt_q == TMO_LAST) begin
               wait_cnt_d    = wait_cnt_q + 1'b1;
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               state_d       = RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= IDLE;
         wait_cnt_q    <= '0;
         paddr_q       <= '0;
         pwrite_q      <= 1'b0;
         pwdata_q      <= '0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         ready_en_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         paddr_q       <= paddr_d;
         pwrite_q      <= pwrite_d;
         pwdata_q      <= pwdata_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         ready_en_q    <= ready_en_d;
      end
   end

   // Bus strobes decode from state so an async reset drops them immediately.
   assign bus.cmd_ready   = (state_q == IDLE) && ready_en_q;
   assign bus.psel        = (state_q == SETUP) || (state_q == ACCESS);
   assign bus.penable     = (state_q == ACCESS);
   assign bus.rsp_valid   = (state_q == RESP);
   assign bus.paddr       = paddr_q;
   assign bus.pwrite      = pwrite_q;
   assign bus.pwdata      = pwdata_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_timeout = rsp_timeout_q;

`ifndef SYNTHESIS
   a_access_addr_stable: assert property (@(posedge pclk) disable iff (!rstn)
      (state_q == ACCESS) |-> $stable({paddr_q, pwrite_q, pwdata_q}));
   a_resp_single_cycle: assert property (@(posedge pclk) disable iff (!rstn)
      (state_q == RESP) |=> (state_q == IDLE));
`endif
endmodule

// File: tb/tb_apb_cmd_master.sv
// Randomized scoreboard bench for apb_cmd_master with a reactive APB slave
// and a latency/response model derived from the transfer rules.
module tb_apb_cmd_master;
   localparam int ADDR_W  = 4;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;

   typedef struct {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      int                waits;
      logic [DATA_W-1:0] prdata;
      logic              slverr;
   } cmd_t;

   typedef struct {
      logic [DATA_W-1:0] rdata;
      logic              err;
      logic              tmo;
      int                cyc;
   } exp_t;

   logic pclk;
   logic rstn;
   int   cyc;
   int   n_checks;
   int   n_miscompares;
   int   last_hs;

   cmd_t slv_q[$];
   exp_t sb_q[$];

   logic [DATA_W-1:0] last_rdata;
   logic              last_err;
   logic              last_tmo;

   apb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .pclk (pclk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   always @(posedge pclk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic cmd_t mk(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                               input int waits, input logic [DATA_W-1:0] rd, input logic se);
      cmd_t c;
      c.write  = w;
      c.addr   = a;
      c.wdata  = wd;
      c.waits  = waits;
      c.prdata = rd;
      c.slverr = se;
      return c;
   endfunction

   // Expected response: completes after 'waits' wait states unless the slave
   // stays busy for the whole TIMEOUT window.
   function automatic exp_t model(input cmd_t c, input int hs);
      exp_t e;
      if (c.waits < TIMEOUT) begin
         e.rdata = c.write ? '0 : c.prdata;
         e.err   = c.slverr;
         e.tmo   = 1'b0;
         e.cyc   = hs + 3 + c.waits;
      end else begin
         e.rdata = '0;
         e.err   = 1'b1;
         e.tmo   = 1'b1;
         e.cyc   = hs + 2 + TIMEOUT;
      end
      return e;
   endfunction

   // Called at posedge+1; returns at posedge+1 just after the handshake edge.
   task automatic apply_stimulus(input cmd_t c);
      bit got;
      got = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = c.write;
      bus.cmd_addr  = c.addr;
      bus.cmd_wdata = c.wdata;
      for (int i = 0; i < 200; i++) begin
         @(negedge pclk);
         if (bus.cmd_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         check_output("handshake_wait", 64'(got), 64'd1);
         return;
      end
      last_hs = cyc;
      sb_q.push_back(model(c, cyc));
      slv_q.push_back(c);
      @(posedge pclk);
      #1;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge pclk);
      #1;
      check_output("drain_empty", 64'(sb_q.size()), 64'd0);
   endtask

   // Reactive APB slave: inserts the command's wait states and checks bus fields.
   initial begin
      cmd_t cur;
      int   acc;
      bit   have;
      have = 1'b0;
      acc = 0;
      bus.pready  = 1'b0;
      bus.prdata  = '0;
      bus.pslverr = 1'b0;
      forever begin
         @(posedge pclk);
         #1;
         if (bus.psel && !bus.penable) begin
            if (slv_q.size() == 0) begin
               check_output("setup_unexpected", 64'(bus.psel), 64'd0);
               have = 1'b0;
            end else begin
               cur  = slv_q.pop_front();
               have = 1'b1;
               acc  = 0;
               check_output("setup_paddr", 64'(bus.paddr), 64'(cur.addr));
               check_output("setup_pwrite", 64'(bus.pwrite), 64'(cur.write));
               check_output("setup_pwdata", 64'(bus.pwdata), 64'(cur.wdata));
            end
         end
         if (bus.psel && bus.penable && have) begin
            check_output("access_paddr", 64'(bus.paddr), 64'(cur.addr));
            check_output("access_pwdata", 64'(bus.pwdata), 64'(cur.wdata));
            if (acc == cur.waits) begin
               bus.pready  = 1'b1;
               bus.prdata  = cur.prdata;
               bus.pslverr = cur.slverr;
            end else begin
               bus.pready  = 1'b0;
               bus.prdata  = $urandom;
               bus.pslverr = 1'($urandom_range(0, 1));
            end
            acc++;
         end else begin
            bus.pready  = 1'($urandom_range(0, 1));
            bus.prdata  = $urandom;
            bus.pslverr = 1'($urandom_range(0, 1));
         end
      end
   end

   // Response monitor: pops the scoreboard on every rsp_valid, else checks hold.
   initial begin
      exp_t e;
      forever begin
         @(negedge pclk);
         if (bus.rsp_valid) begin
            if (sb_q.size() == 0) begin
               check_output("rsp_valid_unexpected", 64'(bus.rsp_valid), 64'd0);
            end else begin
               e = sb_q.pop_front();
               check_output("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
               check_output("rsp_err", 64'(bus.rsp_err), 64'(e.err));
               check_output("rsp_timeout", 64'(bus.rsp_timeout), 64'(e.tmo));
               check_output("rsp_cycle", 64'(cyc), 64'(e.cyc));
               last_rdata = e.rdata;
               last_err   = e.err;
               last_tmo   = e.tmo;
            end
         end else if (rstn) begin
            check_output("hold_rdata", 64'(bus.rsp_rdata), 64'(last_rdata));
            check_output("hold_err", 64'(bus.rsp_err), 64'(last_err));
            check_output("hold_timeout", 64'(bus.rsp_timeout), 64'(last_tmo));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got t=%0t expected done", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      cmd_t c;
      int   h1;
      int   gap;
      n_checks      = 0;
      n_miscompares = 0;
      cyc           = 0;
      last_hs       = 0;
      last_rdata    = '0;
      last_err      = 1'b0;
      last_tmo      = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      rstn = 1'b1;
      #1 rstn = 1'b0;

      repeat (3) @(posedge pclk);
      #1;
      check_output("reset_psel", 64'(bus.psel), 64'd0);
      check_output("reset_penable", 64'(bus.penable), 64'd0);
      check_output("reset_pwrite", 64'(bus.pwrite), 64'd0);
      check_output("reset_paddr", 64'(bus.paddr), 64'd0);
      check_output("reset_pwdata", 64'(bus.pwdata), 64'd0);
      check_output("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check_output("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
      check_output("reset_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
      check_output("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
      @(negedge pclk) rstn = 1'b1;
      @(posedge pclk);
      #1;
      check_output("ready_after_reset", 64'(bus.cmd_ready), 64'd1);

      // zero-wait write with strobe timing
      apply_stimulus(mk(1'b1, 4'h0, 32'h0000_0001, 0, 32'hAAAA_5555, 1'b0));
      bus.cmd_valid = 1'b0;
      check_output("n1_psel", 64'(bus.psel), 64'd1);
      check_output("n1_penable", 64'(bus.penable), 64'd0);
      check_output("n1_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      @(posedge pclk);
      #1;
      check_output("n2_psel", 64'(bus.psel), 64'd1);
      check_output("n2_penable", 64'(bus.penable), 64'd1);
      check_output("n2_pwdata", 64'(bus.pwdata), 64'h1);
      @(posedge pclk);
      #1;
      check_output("n3_psel", 64'(bus.psel), 64'd0);
      check_output("n3_penable", 64'(bus.penable), 64'd0);
      wait_drain();

      // read with three wait states
      apply_stimulus(mk(1'b0, 4'h4, 32'h1357_9BDF, 3, 32'hDEAD_BEEF, 1'b0));
      bus.cmd_valid = 1'b0;
      wait_drain();

      // write with slave error
      apply_stimulus(mk(1'b1, 4'h7, 32'hCAFE_F00D, 1, 32'h0, 1'b1));
      bus.cmd_valid = 1'b0;
      wait_drain();

      // timeout boundary: ready on the last allowed cycle, then never ready
      apply_stimulus(mk(1'b0, 4'hA, 32'h0, TIMEOUT - 1, 32'h8765_4321, 1'b0));
      bus.cmd_valid = 1'b0;
      wait_drain();
      apply_stimulus(mk(1'b0, 4'hB, 32'h0, TIMEOUT, 32'h1111_2222, 1'b0));
      bus.cmd_valid = 1'b0;
      wait_drain();

      // back-to-back with cmd_valid held high
      apply_stimulus(mk(1'b1, 4'h2, 32'h0000_00A1, 0, 32'h0, 1'b0));
      h1 = last_hs;
      apply_stimulus(mk(1'b0, 4'h3, 32'h0000_00B2, 0, 32'h0BAD_CAFE, 1'b0));
      bus.cmd_valid = 1'b0;
      check_output("b2b_gap", 64'(last_hs - h1), 64'd4);
      wait_drain();

      // reset pulse during ACCESS
      apply_stimulus(mk(1'b0, 4'h9, 32'h0, 5, 32'h1234_5678, 1'b0));
      bus.cmd_valid = 1'b0;
      @(posedge pclk);
      #1;
      @(posedge pclk);
      #1;
      check_output("pre_reset_psel", 64'(bus.psel), 64'd1);
      check_output("pre_reset_penable", 64'(bus.penable), 64'd1);
      #1 rstn = 1'b0;
      #1;
      check_output("async_reset_psel", 64'(bus.psel), 64'd0);
      check_output("async_reset_penable", 64'(bus.penable), 64'd0);
      sb_q.delete();
      slv_q.delete();
      last_rdata = '0;
      last_err   = 1'b0;
      last_tmo   = 1'b0;
      repeat (3) @(posedge pclk);
      @(negedge pclk) rstn = 1'b1;
      @(posedge pclk);
      #1;
      check_output("ready_after_midreset", 64'(bus.cmd_ready), 64'd1);

      // randomized traffic, occasionally back-to-back
      for (int i = 0; i < 40; i++) begin
         c.write  = 1'($urandom_range(0, 1));
         c.addr   = ADDR_W'($urandom);
         c.wdata  = $urandom;
         c.prdata = $urandom;
         c.slverr = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 9) < 7) c.waits = $urandom_range(0, 3);
         else c.waits = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
         apply_stimulus(c);
         gap = $urandom_range(0, 2);
         if (gap > 0) begin
            bus.cmd_valid = 1'b0;
            repeat (gap) @(posedge pclk);
            #1;
         end
      end
      bus.cmd_valid = 1'b0;
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompares);
      $finish;
   end
endmodule
